// File: rtl/nrisk_pkg.sv
// nRisk shared definitions: opcodes, control states, instruction fields.
// Imported by the control unit and its ALU.
package nrisk_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int PC_W_DEF   = 8;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_LI   = 3'b001;
    localparam logic [2:0] OP_MOV  = 3'b010;
    localparam logic [2:0] OP_ADD  = 3'b011;
    localparam logic [2:0] OP_SUB  = 3'b100;
    localparam logic [2:0] OP_NOT  = 3'b101;
    localparam logic [2:0] OP_JZ   = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    localparam int OP_HI  = 7;
    localparam int OP_LO  = 5;
    localparam int RD_BIT = 4;
    localparam int RS_BIT = 3;
    localparam int IMM_HI = 2;
    localparam int IMM_LO = 0;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_READ_A,
        S_READ_B,
        S_EXEC,
        S_WRITE,
        S_HALT
    } state_t;

endpackage

// File: rtl/ula_nrisk.sv
// nRisk ALU: combinational, modulo-2^DATA_W, no flags except zero-of-a.
// zero feeds the JZ branch decision.
module ula_nrisk
    import nrisk_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [2:0]        i_op,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic [2:0]        i_imm3,
    output logic [DATA_W-1:0] o_result,
    output logic              o_zero
);

    always_comb begin
        o_result = i_a;
        unique case (i_op)
            OP_LI:   o_result = {{(DATA_W-3){1'b0}}, i_imm3};
            OP_MOV:  o_result = i_b;
            OP_ADD:  o_result = i_a + i_b;
            OP_SUB:  o_result = i_a - i_b;
            OP_NOT:  o_result = ~i_a;
            default: o_result = i_a;
        endcase
    end

    assign o_zero = (i_a == '0);

endmodule

// File: rtl/unidade_controle.sv
// nRisk multi-cycle control unit: fetches from instruction ROM and
// sequences reads/writes on the two-entry register bank.
module unidade_controle
    import nrisk_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int PC_W   = PC_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    output logic [PC_W-1:0]   pc,
    input  logic [7:0]        instr,
    output logic              br_sinal,
    output logic              br_registrador,
    output logic [DATA_W-1:0] br_valor_escrita,
    input  logic [DATA_W-1:0] br_valor_saida,
    output logic              halted
);

    state_t            r_state;
    logic [PC_W-1:0]   r_pc;
    logic [7:0]        r_ir;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_result;

    logic [2:0]        w_op;
    logic              w_rd;
    logic              w_rs;
    logic [2:0]        w_imm3;
    logic [DATA_W-1:0] w_alu_res;
    logic              w_zero;
    logic [PC_W-1:0]   w_pc_inc;
    logic [PC_W-1:0]   w_pc_jmp;

    assign w_op     = r_ir[OP_HI:OP_LO];
    assign w_rd     = r_ir[RD_BIT];
    assign w_rs     = r_ir[RS_BIT];
    assign w_imm3   = r_ir[IMM_HI:IMM_LO];
    assign w_pc_inc = r_pc + PC_W'(1);
    // JZ offset is relative to the JZ's own address
    assign w_pc_jmp = r_pc + {{(PC_W-3){w_imm3[2]}}, w_imm3};

    ula_nrisk #(
        .DATA_W (DATA_W)
    ) u_ula (
        .i_op     (w_op),
        .i_a      (r_a),
        .i_b      (r_b),
        .i_imm3   (w_imm3),
        .o_result (w_alu_res),
        .o_zero   (w_zero)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state  <= S_FETCH;
            r_pc     <= '0;
            r_ir     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
        end else begin
            unique case (r_state)
                S_FETCH: begin
                    r_ir    <= instr;
                    r_state <= S_DECODE;
                end
                S_DECODE: begin
                    unique case (w_op)
                        OP_NOP: begin
                            r_pc    <= w_pc_inc;
                            r_state <= S_FETCH;
                        end
                        OP_LI: begin
                            r_result <= w_alu_res;
                            r_state  <= S_WRITE;
                        end
                        OP_MOV:  r_state <= S_READ_B;
                        OP_HALT: r_state <= S_HALT;
                        default: r_state <= S_READ_A;
                    endcase
                end
                S_READ_A: begin
                    r_a <= br_valor_saida;
                    if (w_op == OP_ADD || w_op == OP_SUB)
                        r_state <= S_READ_B;
                    else
                        r_state <= S_EXEC;
                end
                S_READ_B: begin
                    r_b     <= br_valor_saida;
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    r_result <= w_alu_res;
                    if (w_op == OP_JZ) begin
                        r_pc    <= w_zero ? w_pc_jmp : w_pc_inc;
                        r_state <= S_FETCH;
                    end else begin
                        r_state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    r_pc    <= w_pc_inc;
                    r_state <= S_FETCH;
                end
                S_HALT: r_state <= S_HALT;
                default: r_state <= S_FETCH;
            endcase
        end
    end

    // reset gates the strobe so a mid-WRITE reset never commits
    assign br_sinal         = (r_state == S_WRITE) && reset;
    assign br_registrador   = (r_state == S_READ_B) ? w_rs : w_rd;
    assign br_valor_escrita = r_result;
    assign pc               = r_pc;
    assign halted           = (r_state == S_HALT);

endmodule

// File: tb/tb_unidade_controle.sv
// Bench for unidade_controle: ROM and register bank modelled here,
// directed vectors, corner sequences and an ISA-level random model.
module tb_unidade_controle;

    localparam int NCYC = 200;
    localparam int NV   = 15;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] pc;
    logic [7:0] instr;
    logic       br_sinal;
    logic       br_registrador;
    logic [7:0] br_valor_escrita;
    logic [7:0] br_valor_saida;
    logic       halted;

    logic [7:0] rom [256];
    logic [7:0] bank [2];
    logic       tb_load = 1'b0;
    logic [7:0] l0 = 8'h00;
    logic [7:0] l1 = 8'h00;

    int checks = 0;
    int errors = 0;

    unidade_controle dut (
        .clock            (clock),
        .reset            (reset),
        .pc               (pc),
        .instr            (instr),
        .br_sinal         (br_sinal),
        .br_registrador   (br_registrador),
        .br_valor_escrita (br_valor_escrita),
        .br_valor_saida   (br_valor_saida),
        .halted           (halted)
    );

    always #5 clock = ~clock;

    assign instr          = rom[pc];
    assign br_valor_saida = bank[br_registrador];

    always @(posedge clock) begin
        if (tb_load) begin
            bank[0] <= l0;
            bank[1] <= l1;
        end else if (br_sinal) begin
            bank[br_registrador] <= br_valor_escrita;
        end
    end

    typedef struct {
        logic [7:0] pc;
        logic [7:0] ins;
        logic [7:0] r0;
        logic [7:0] r1;
        int         lat;
        logic       wr;
        logic       wreg;
        logic [7:0] wval;
        logic [7:0] npc;
    } vec_t;

    typedef struct {
        logic [7:0] pc;
        logic       s;
        logic       r;
        logic [7:0] v;
        logic       h;
    } cyc_t;

    vec_t vt [NV];
    cyc_t exp_q [$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, expv);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic fill_rom(input logic [7:0] v);
        for (int k = 0; k < 256; k++) rom[k] = v;
    endtask

    // leaves the bench one cycle into FETCH at pc 0 with reset released
    task automatic do_reset(input logic [7:0] v0, input logic [7:0] v1);
        reset   = 1'b0;
        tb_load = 1'b1;
        l0      = v0;
        l1      = v1;
        step();
        step();
        tb_load = 1'b0;
        reset   = 1'b1;
    endtask

    // instruction-level interpreter expanded to per-cycle expectations
    task automatic build_model(input logic [7:0] r0i, input logic [7:0] r1i);
        logic [7:0] m [2];
        logic [7:0] p, ins, wv, np, off;
        logic [2:0] op;
        logic       rd, rs, wr, hlt;
        int         lat;
        cyc_t       e;
        exp_q.delete();
        m[0] = r0i;
        m[1] = r1i;
        p    = 8'h00;
        hlt  = 1'b0;
        while (exp_q.size() < NCYC) begin
            ins = rom[p];
            op  = ins[7:5];
            rd  = ins[4];
            rs  = ins[3];
            off = {{5{ins[2]}}, ins[2:0]};
            wr  = 1'b0;
            wv  = 8'h00;
            np  = p + 8'd1;
            case (op)
                3'd0: lat = 2;
                3'd1: begin lat = 3; wr = 1; wv = {5'b0, ins[2:0]}; end
                3'd2: begin lat = 5; wr = 1; wv = m[rs]; end
                3'd3: begin lat = 6; wr = 1; wv = m[rd] + m[rs]; end
                3'd4: begin lat = 6; wr = 1; wv = m[rd] - m[rs]; end
                3'd5: begin lat = 5; wr = 1; wv = ~m[rd]; end
                3'd6: begin
                    lat = 4;
                    if (m[rd] == 8'h00) np = p + off;
                end
                default: begin lat = 2; hlt = 1'b1; end
            endcase
            for (int k = 0; k < lat; k++) begin
                e.pc = p;
                e.s  = wr && (k == lat - 1);
                e.r  = rd;
                e.v  = wv;
                e.h  = 1'b0;
                exp_q.push_back(e);
            end
            if (hlt) begin
                while (exp_q.size() < NCYC) begin
                    e.pc = p;
                    e.s  = 1'b0;
                    e.r  = 1'b0;
                    e.v  = 8'h00;
                    e.h  = 1'b1;
                    exp_q.push_back(e);
                end
            end
            if (wr) m[rd] = wv;
            p = np;
        end
    endtask

    initial begin
        int         n, lat, nw;
        logic       wreg;
        logic [7:0] wval, x, r0i, r1i;
        int         pcyc [4];
        logic       preg [4];
        logic [7:0] pval [4];
        cyc_t       e;

        //        pc     ins    r0     r1     lat wr reg  wval   npc
        vt[0]  = '{8'h00, 8'h25, 8'h11, 8'h22, 3, 1, 0, 8'h05, 8'h01};
        vt[1]  = '{8'h00, 8'h37, 8'h00, 8'h00, 3, 1, 1, 8'h07, 8'h01};
        vt[2]  = '{8'h00, 8'h48, 8'h12, 8'h9A, 5, 1, 0, 8'h9A, 8'h01};
        vt[3]  = '{8'h00, 8'h58, 8'h00, 8'h3C, 5, 1, 1, 8'h3C, 8'h01};
        vt[4]  = '{8'h00, 8'h68, 8'hF0, 8'h20, 6, 1, 0, 8'h10, 8'h01};
        vt[5]  = '{8'h00, 8'h88, 8'h02, 8'h03, 6, 1, 0, 8'hFF, 8'h01};
        vt[6]  = '{8'h00, 8'hA0, 8'hFF, 8'h00, 5, 1, 0, 8'h00, 8'h01};
        vt[7]  = '{8'h00, 8'h90, 8'h05, 8'h07, 6, 1, 1, 8'h02, 8'h01};
        vt[8]  = '{8'h00, 8'hB0, 8'h00, 8'h5A, 5, 1, 1, 8'hA5, 8'h01};
        vt[9]  = '{8'h05, 8'hC6, 8'h00, 8'h00, 4, 0, 0, 8'h00, 8'h03};
        vt[10] = '{8'h05, 8'hC6, 8'h01, 8'h00, 4, 0, 0, 8'h00, 8'h06};
        vt[11] = '{8'hFF, 8'h00, 8'h00, 8'h00, 2, 0, 0, 8'h00, 8'h00};
        vt[12] = '{8'h01, 8'hC6, 8'h00, 8'h00, 4, 0, 0, 8'h00, 8'hFF};
        vt[13] = '{8'h02, 8'hD3, 8'h07, 8'h00, 4, 0, 0, 8'h00, 8'h05};
        vt[14] = '{8'h03, 8'h00, 8'h00, 8'h00, 2, 0, 0, 8'h00, 8'h04};

        fill_rom(8'h00);
        rom[0] = 8'h20;

        // reset held with LI r0,0 on the bus
        for (int c = 0; c < 3; c++) begin
            step();
            chk($sformatf("rst_pc_%0d", c), pc, 8'h00);
            chk($sformatf("rst_we_%0d", c), br_sinal, 1'b0);
            chk($sformatf("rst_halt_%0d", c), halted, 1'b0);
        end
        reset = 1'b1;
        chk("rel_pc", pc, 8'h00);
        step();
        step();
        chk("rel_li_we", br_sinal, 1'b1);
        chk("rel_li_reg", br_registrador, 1'b0);
        chk("rel_li_val", br_valor_escrita, 8'h00);

        // single-instruction vectors
        for (int i = 0; i < NV; i++) begin
            fill_rom(8'h00);
            rom[vt[i].pc] = vt[i].ins;
            do_reset(vt[i].r0, vt[i].r1);
            n = 0;
            while (pc !== vt[i].pc && n < 600) begin
                step();
                n++;
            end
            chk($sformatf("v%0d_reach", i), pc, vt[i].pc);
            lat  = 0;
            nw   = 0;
            wreg = 1'b0;
            wval = 8'h00;
            while (pc === vt[i].pc && lat < 20) begin
                if (br_sinal) begin
                    nw++;
                    wreg = br_registrador;
                    wval = br_valor_escrita;
                end
                step();
                lat++;
            end
            chk($sformatf("v%0d_lat", i), lat, vt[i].lat);
            chk($sformatf("v%0d_nwr", i), nw, vt[i].wr ? 1 : 0);
            if (vt[i].wr) begin
                chk($sformatf("v%0d_reg", i), wreg, vt[i].wreg);
                chk($sformatf("v%0d_val", i), wval, vt[i].wval);
            end
            chk($sformatf("v%0d_npc", i), pc, vt[i].npc);
        end

        // LI r0,5 ; LI r1,3 ; ADD r0,r1
        fill_rom(8'hE0);
        rom[0] = 8'h25;
        rom[1] = 8'h33;
        rom[2] = 8'h68;
        do_reset(8'h00, 8'h00);
        nw = 0;
        for (int c = 0; c < 16; c++) begin
            if (br_sinal) begin
                if (nw < 4) begin
                    pcyc[nw] = c;
                    preg[nw] = br_registrador;
                    pval[nw] = br_valor_escrita;
                end
                nw++;
            end
            step();
        end
        chk("prog_npulse", nw, 3);
        if (nw >= 3) begin
            chk("prog_p0_cyc", pcyc[0], 2);
            chk("prog_p0_reg", preg[0], 1'b0);
            chk("prog_p0_val", pval[0], 8'h05);
            chk("prog_p1_cyc", pcyc[1], 5);
            chk("prog_p1_reg", preg[1], 1'b1);
            chk("prog_p1_val", pval[1], 8'h03);
            chk("prog_p2_cyc", pcyc[2], 11);
            chk("prog_p2_reg", preg[2], 1'b0);
            chk("prog_p2_val", pval[2], 8'h08);
        end
        chk("prog_bank_r0", bank[0], 8'h08);

        // reset landing on the WRITE cycle of LI r1,7, then HALT
        fill_rom(8'hE0);
        rom[0] = 8'h37;
        do_reset(8'h00, 8'h55);
        step();
        step();
        chk("mw_we_pre", br_sinal, 1'b1);
        reset = 1'b0;
        #1;
        chk("mw_we_gated", br_sinal, 1'b0);
        step();
        chk("mw_bank_r1", bank[1], 8'h55);
        chk("mw_pc", pc, 8'h00);
        rom[0] = 8'hE0;
        reset  = 1'b1;
        step();
        step();
        for (int c = 0; c < 20; c++) begin
            chk($sformatf("halt_h_%0d", c), halted, 1'b1);
            chk($sformatf("halt_pc_%0d", c), pc, 8'h00);
            chk($sformatf("halt_we_%0d", c), br_sinal, 1'b0);
            step();
        end
        reset = 1'b0;
        step();
        chk("halt_rst_h", halted, 1'b0);
        chk("halt_rst_pc", pc, 8'h00);
        reset = 1'b1;

        // random programs against the instruction-level model
        for (int t = 0; t < 20; t++) begin
            for (int k = 0; k < 256; k++) begin
                x = 8'($urandom);
                if (x[7:5] == 3'b111 && $urandom_range(0, 3) != 0)
                    x[7:5] = 3'b000;
                rom[k] = x;
            end
            r0i = 8'($urandom);
            r1i = 8'($urandom);
            if (t % 4 == 0) r0i = 8'h00;
            do_reset(r0i, r1i);
            build_model(r0i, r1i);
            for (int c = 0; c < NCYC; c++) begin
                e = exp_q[c];
                chk($sformatf("rnd%0d_c%0d_pc", t, c), pc, e.pc);
                chk($sformatf("rnd%0d_c%0d_we", t, c), br_sinal, e.s);
                chk($sformatf("rnd%0d_c%0d_h", t, c), halted, e.h);
                if (e.s) begin
                    chk($sformatf("rnd%0d_c%0d_reg", t, c),
                        br_registrador, e.r);
                    chk($sformatf("rnd%0d_c%0d_val", t, c),
                        br_valor_escrita, e.v);
                end
                step();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
